// File: rtl/axi_arb_pkg.sv
// Shared types for the AXI-lite arbiter: bus widths, FSM states and grant type.
package axi_arb_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int STRB_W = DATA_W / 8;
   localparam int RESP_W = 2;

   typedef enum logic [2:0] {
      IDLE,
      RD_ADDR,
      RD_DATA,
      WR_ADDR,
      WR_RESP
   } arb_state_t;

   typedef enum logic {
      RD,
      WR
   } grant_type_t;

endpackage

// File: rtl/axi_lite_if.sv
// AXI-lite bundle; the master modport drives addresses, write data and response readies.
interface axi_lite_if;
   import axi_arb_pkg::*;

   logic [ADDR_W-1:0] araddr;
   logic              arvalid;
   logic              arready;
   logic [DATA_W-1:0] rdata;
   logic [RESP_W-1:0] rresp;
   logic              rvalid;
   logic              rready;
   logic [ADDR_W-1:0] awaddr;
   logic              awvalid;
   logic              awready;
   logic [DATA_W-1:0] wdata;
   logic [STRB_W-1:0] wmask;
   logic              wvalid;
   logic              wready;
   logic [RESP_W-1:0] bresp;
   logic              bvalid;
   logic              bready;

   modport master (
      output araddr, arvalid, rready, awaddr, awvalid, wdata, wmask, wvalid, bready,
      input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );

   modport slave (
      input  araddr, arvalid, rready, awaddr, awvalid, wdata, wmask, wvalid, bready,
      output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin winner selection, starting one past the last grant.
module rr_picker #(
   parameter int NUM_MASTERS = 2,
   parameter int IDX_W       = 1
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [IDX_W-1:0]       last_grant,
   output logic                   valid,
   output logic [IDX_W-1:0]       index
);

   function automatic int wrap_idx(input int base, input int offset);
      return (base + offset) % NUM_MASTERS;
   endfunction

   // Offset NUM_MASTERS wraps back to last_grant itself, so it is searched last.
   always_comb begin
      valid = 1'b0;
      index = '0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         if (!valid && req[wrap_idx(int'(last_grant), k)]) begin
            valid = 1'b1;
            index = IDX_W'(wrap_idx(int'(last_grant), k));
         end
      end
   end

endmodule

// File: rtl/axi_lite_arbiter.sv
// N:1 AXI-lite arbiter allowing a single outstanding read or write on the shared port.
module axi_lite_arbiter
   import axi_arb_pkg::*;
#(
   parameter int NUM_MASTERS = 2
) (
   input logic       clk,
   input logic       reset,
   axi_lite_if.slave m [NUM_MASTERS],
   axi_lite_if.master s
);

   localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   arb_state_t  state, next_state;
   grant_type_t grant_type;
   logic [IDX_W-1:0] grant_idx, last_grant, pick_index;
   logic pick_valid, aw_done, w_done;

   logic [NUM_MASTERS-1:0] m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
   logic [ADDR_W-1:0] m_araddr [NUM_MASTERS];
   logic [ADDR_W-1:0] m_awaddr [NUM_MASTERS];
   logic [DATA_W-1:0] m_wdata [NUM_MASTERS];
   logic [STRB_W-1:0] m_wmask [NUM_MASTERS];

   logic granted, ar_phase, r_phase, wa_phase, b_phase;
   logic s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
   logic aw_fire, w_fire;

   rr_picker #(
      .NUM_MASTERS(NUM_MASTERS),
      .IDX_W      (IDX_W)
   ) u_picker (
      .req       (m_arvalid | m_awvalid),
      .last_grant(last_grant),
      .valid     (pick_valid),
      .index     (pick_index)
   );

   // Reset gates every phase so no handshake can leak out while state is being cleared.
   assign granted  = (state != IDLE) && !reset;
   assign ar_phase = granted && (state == RD_ADDR) && (grant_type == RD);
   assign r_phase  = granted && (state == RD_DATA) && (grant_type == RD);
   assign wa_phase = granted && (state == WR_ADDR) && (grant_type == WR);
   assign b_phase  = granted && (state == WR_RESP) && (grant_type == WR);

   assign s_arvalid = ar_phase && m_arvalid[grant_idx];
   assign s_rready  = r_phase && m_rready[grant_idx];
   assign s_awvalid = wa_phase && !aw_done && m_awvalid[grant_idx];
   assign s_wvalid  = wa_phase && !w_done && m_wvalid[grant_idx];
   assign s_bready  = b_phase && m_bready[grant_idx];
   assign aw_fire   = s_awvalid && s.awready;
   assign w_fire    = s_wvalid && s.wready;

   assign s.arvalid = s_arvalid;
   assign s.rready  = s_rready;
   assign s.awvalid = s_awvalid;
   assign s.wvalid  = s_wvalid;
   assign s.bready  = s_bready;
   assign s.araddr  = granted ? m_araddr[grant_idx] : '0;
   assign s.awaddr  = granted ? m_awaddr[grant_idx] : '0;
   assign s.wdata   = granted ? m_wdata[grant_idx] : '0;
   assign s.wmask   = granted ? m_wmask[grant_idx] : '0;

   for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_master
      logic sel;
      assign sel = (grant_idx == IDX_W'(i));

      assign m_arvalid[i] = m[i].arvalid;
      assign m_rready[i]  = m[i].rready;
      assign m_awvalid[i] = m[i].awvalid;
      assign m_wvalid[i]  = m[i].wvalid;
      assign m_bready[i]  = m[i].bready;
      assign m_araddr[i]  = m[i].araddr;
      assign m_awaddr[i]  = m[i].awaddr;
      assign m_wdata[i]   = m[i].wdata;
      assign m_wmask[i]   = m[i].wmask;

      assign m[i].arready = ar_phase && sel && s.arready;
      assign m[i].rvalid  = r_phase && sel && s.rvalid;
      assign m[i].awready = wa_phase && sel && !aw_done && s.awready;
      assign m[i].wready  = wa_phase && sel && !w_done && s.wready;
      assign m[i].bvalid  = b_phase && sel && s.bvalid;
      assign m[i].rdata   = s.rdata;
      assign m[i].rresp   = s.rresp;
      assign m[i].bresp   = s.bresp;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (pick_valid) next_state = m_arvalid[pick_index] ? RD_ADDR : WR_ADDR;
         RD_ADDR: if (s_arvalid && s.arready) next_state = RD_DATA;
         RD_DATA: if (s.rvalid && s_rready) next_state = IDLE;
         WR_ADDR: if ((aw_done || aw_fire) && (w_done || w_fire)) next_state = WR_RESP;
         WR_RESP: if (s.bvalid && s_bready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Done flags remember which write channel already completed, so AW and W may finish in either order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         grant_idx  <= '0;
         grant_type <= RD;
         last_grant <= IDX_W'(NUM_MASTERS - 1);
         aw_done    <= 1'b0;
         w_done     <= 1'b0;
      end else begin
         state <= next_state;
         if (state == IDLE && pick_valid) begin
            grant_idx  <= pick_index;
            grant_type <= m_arvalid[pick_index] ? RD : WR;
            last_grant <= pick_index;
         end
         if (state == WR_ADDR) begin
            if (next_state == WR_RESP) begin
               aw_done <= 1'b0;
               w_done  <= 1'b0;
            end else begin
               if (aw_fire) aw_done <= 1'b1;
               if (w_fire)  w_done  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter with two masters and a hand-driven downstream slave.
module tb_axi_lite_arbiter;
   import axi_arb_pkg::*;

   logic clk, reset;
   logic [1:0] m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
   logic [31:0] m_araddr [2];
   logic [31:0] m_awaddr [2];
   logic [31:0] m_wdata [2];
   logic [3:0]  m_wmask [2];
   logic [1:0] m_arready, m_rvalid, m_awready, m_wready, m_bvalid;
   logic [31:0] m_rdata [2];
   logic [1:0]  m_rresp [2];
   logic [1:0]  m_bresp [2];

   logic s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp, s_bresp;
   logic s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
   logic [31:0] s_araddr, s_awaddr, s_wdata;
   logic [3:0]  s_wmask;

   int checks = 0;
   int failures = 0;
   int w_hs = 0;
   int aw_hs = 0;
   int aw_valid_cycles = 0;
   int w_start, aw_start, awv_start;

   axi_lite_if m_if [2] ();
   axi_lite_if s_if ();

   axi_lite_arbiter #(.NUM_MASTERS(2)) dut (
      .clk  (clk),
      .reset(reset),
      .m    (m_if),
      .s    (s_if)
   );

   for (genvar i = 0; i < 2; i++) begin : g_tb_master
      assign m_if[i].arvalid = m_arvalid[i];
      assign m_if[i].araddr  = m_araddr[i];
      assign m_if[i].rready  = m_rready[i];
      assign m_if[i].awvalid = m_awvalid[i];
      assign m_if[i].awaddr  = m_awaddr[i];
      assign m_if[i].wvalid  = m_wvalid[i];
      assign m_if[i].wdata   = m_wdata[i];
      assign m_if[i].wmask   = m_wmask[i];
      assign m_if[i].bready  = m_bready[i];
      assign m_arready[i] = m_if[i].arready;
      assign m_rvalid[i]  = m_if[i].rvalid;
      assign m_awready[i] = m_if[i].awready;
      assign m_wready[i]  = m_if[i].wready;
      assign m_bvalid[i]  = m_if[i].bvalid;
      assign m_rdata[i]   = m_if[i].rdata;
      assign m_rresp[i]   = m_if[i].rresp;
      assign m_bresp[i]   = m_if[i].bresp;
   end

   assign s_if.arready = s_arready;
   assign s_if.rvalid  = s_rvalid;
   assign s_if.rdata   = s_rdata;
   assign s_if.rresp   = s_rresp;
   assign s_if.awready = s_awready;
   assign s_if.wready  = s_wready;
   assign s_if.bvalid  = s_bvalid;
   assign s_if.bresp   = s_bresp;
   assign s_arvalid = s_if.arvalid;
   assign s_araddr  = s_if.araddr;
   assign s_rready  = s_if.rready;
   assign s_awvalid = s_if.awvalid;
   assign s_awaddr  = s_if.awaddr;
   assign s_wvalid  = s_if.wvalid;
   assign s_wdata   = s_if.wdata;
   assign s_wmask   = s_if.wmask;
   assign s_bready  = s_if.bready;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Handshake counters on the shared port, used to prove each channel completes exactly once.
   always @(posedge clk) begin
      if (s_wvalid && s_wready) w_hs <= w_hs + 1;
      if (s_awvalid && s_awready) aw_hs <= aw_hs + 1;
      if (s_awvalid) aw_valid_cycles <= aw_valid_cycles + 1;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic check_bit(input string tag, input logic observed, input logic expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   task automatic check_word(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   initial begin
      reset = 1'b1;
      m_arvalid = '0; m_rready = 2'b11; m_awvalid = '0; m_wvalid = '0; m_bready = 2'b11;
      for (int i = 0; i < 2; i++) begin
         m_araddr[i] = '0; m_awaddr[i] = '0; m_wdata[i] = '0; m_wmask[i] = '0;
      end
      s_arready = 1'b1; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
      s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = '0;

      // Single read from master 0, request already pending while reset is held.
      m_arvalid[0] = 1'b1;
      m_araddr[0]  = 32'h8000_0010;
      tick();
      settle();
      check_bit("rst_s_arvalid", s_arvalid, 1'b0);
      check_bit("rst_m0_arready", m_arready[0], 1'b0);
      tick();
      reset = 1'b0;
      settle();
      check_bit("post_rst_s_arvalid", s_arvalid, 1'b0);
      check_word("post_rst_s_araddr", s_araddr, 32'h0);
      check_word("post_rst_state", 32'(dut.state), 32'(IDLE));
      check_word("post_rst_last_grant", 32'(dut.last_grant), 32'd1);
      tick();
      settle();
      check_bit("rd_s_arvalid", s_arvalid, 1'b1);
      check_word("rd_s_araddr", s_araddr, 32'h8000_0010);
      check_bit("rd_m0_arready", m_arready[0], 1'b1);
      tick();
      m_arvalid[0] = 1'b0;
      settle();
      check_bit("rd_data_s_rready", s_rready, 1'b1);
      check_bit("rd_data_m0_rvalid_wait", m_rvalid[0], 1'b0);
      tick();
      s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b00;
      settle();
      check_bit("rd_m0_rvalid", m_rvalid[0], 1'b1);
      check_word("rd_m0_rdata", m_rdata[0], 32'hDEAD_BEEF);
      check_word("rd_m0_rresp", 32'(m_rresp[0]), 32'd0);
      check_bit("rd_m1_rvalid", m_rvalid[1], 1'b0);
      check_word("rd_m1_rdata_bcast", m_rdata[1], 32'hDEAD_BEEF);
      tick();
      s_rvalid = 1'b0;
      settle();
      check_word("rd_done_state", 32'(dut.state), 32'(IDLE));
      check_bit("rd_done_m0_rvalid", m_rvalid[0], 1'b0);

      // Contention: both masters request the same cycle after reset.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_arvalid = 2'b11;
      m_araddr[0] = 32'h0000_0100;
      m_araddr[1] = 32'h0000_0200;
      settle();
      check_bit("cont_idle_s_arvalid", s_arvalid, 1'b0);
      tick();
      settle();
      check_word("cont1_s_araddr", s_araddr, 32'h0000_0100);
      check_bit("cont1_m0_arready", m_arready[0], 1'b1);
      check_bit("cont1_m1_arready", m_arready[1], 1'b0);
      tick();
      m_arvalid[0] = 1'b0;
      s_rvalid = 1'b1; s_rdata = 32'h0000_0011;
      settle();
      check_bit("cont1_m0_rvalid", m_rvalid[0], 1'b1);
      check_bit("cont1_m1_rvalid", m_rvalid[1], 1'b0);
      check_bit("cont1_m1_waits", s_arvalid, 1'b0);
      tick();
      s_rvalid = 1'b0;
      settle();
      check_bit("cont_gap_s_arvalid", s_arvalid, 1'b0);
      tick();
      settle();
      check_word("cont2_s_araddr", s_araddr, 32'h0000_0200);
      check_bit("cont2_m1_arready", m_arready[1], 1'b1);
      check_bit("cont2_m0_arready", m_arready[0], 1'b0);
      tick();
      m_arvalid[1] = 1'b0;
      s_rvalid = 1'b1; s_rdata = 32'h0000_0022;
      settle();
      check_bit("cont2_m1_rvalid", m_rvalid[1], 1'b1);
      check_bit("cont2_m0_rvalid", m_rvalid[0], 1'b0);
      tick();
      s_rvalid = 1'b0;
      m_arvalid = 2'b11;
      tick();
      settle();
      check_word("cont3_s_araddr", s_araddr, 32'h0000_0100);
      check_bit("cont3_m0_arready", m_arready[0], 1'b1);

      // Backpressure: master 0 withholds rready while master 1 is still pending.
      tick();
      m_arvalid[0] = 1'b0;
      m_rready[0] = 1'b0;
      s_rvalid = 1'b1; s_rdata = 32'h0000_0033;
      for (int c = 0; c < 5; c++) begin
         settle();
         check_bit("bp_s_rready", s_rready, 1'b0);
         check_word("bp_state", 32'(dut.state), 32'(RD_DATA));
         check_bit("bp_m1_not_granted", s_arvalid, 1'b0);
         tick();
      end
      m_rready[0] = 1'b1;
      settle();
      check_bit("bp_release_s_rready", s_rready, 1'b1);
      tick();
      s_rvalid = 1'b0;
      tick();
      settle();
      check_word("bp_m1_s_araddr", s_araddr, 32'h0000_0200);
      check_bit("bp_m1_arready", m_arready[1], 1'b1);
      tick();
      m_arvalid[1] = 1'b0;
      s_rvalid = 1'b1;
      settle();
      check_bit("bp_m1_rvalid", m_rvalid[1], 1'b1);
      tick();
      s_rvalid = 1'b0;

      // Write skew on master 1: W presented three cycles ahead of AW.
      m_wvalid[1] = 1'b1;
      m_wdata[1]  = 32'h0000_0041;
      m_wmask[1]  = 4'h1;
      settle();
      check_bit("skew_idle_s_wvalid", s_wvalid, 1'b0);
      tick(); tick(); tick();
      settle();
      check_word("skew_w_only_state", 32'(dut.state), 32'(IDLE));
      m_awvalid[1] = 1'b1;
      m_awaddr[1]  = 32'hA000_03F8;
      s_awready = 1'b0; s_wready = 1'b1;
      w_start = w_hs; aw_start = aw_hs;
      settle();
      check_bit("skew_idle_s_awvalid", s_awvalid, 1'b0);
      tick();
      settle();
      check_bit("skew_s_wvalid", s_wvalid, 1'b1);
      check_word("skew_s_wdata", s_wdata, 32'h0000_0041);
      check_word("skew_s_wmask", 32'(s_wmask), 32'h1);
      check_bit("skew_m1_wready", m_wready[1], 1'b1);
      check_bit("skew_s_awvalid", s_awvalid, 1'b1);
      check_word("skew_s_awaddr", s_awaddr, 32'hA000_03F8);
      check_bit("skew_m1_awready_blocked", m_awready[1], 1'b0);
      tick();
      settle();
      check_bit("skew_w_masked_valid", s_wvalid, 1'b0);
      check_bit("skew_w_masked_ready", m_wready[1], 1'b0);
      check_bit("skew_w_done", dut.w_done, 1'b1);
      check_word("skew_wait_aw_state", 32'(dut.state), 32'(WR_ADDR));
      s_awready = 1'b1;
      settle();
      check_bit("skew_m1_awready", m_awready[1], 1'b1);
      tick();
      m_awvalid[1] = 1'b0; m_wvalid[1] = 1'b0;
      s_bvalid = 1'b1; s_bresp = 2'b10;
      settle();
      check_word("skew_state_wresp", 32'(dut.state), 32'(WR_RESP));
      check_word("skew_w_handshakes", 32'(w_hs - w_start), 32'd1);
      check_word("skew_aw_handshakes", 32'(aw_hs - aw_start), 32'd1);
      check_bit("skew_flags_cleared", dut.aw_done | dut.w_done, 1'b0);
      check_bit("skew_m1_bvalid", m_bvalid[1], 1'b1);
      check_bit("skew_m0_bvalid", m_bvalid[0], 1'b0);
      check_word("skew_m1_bresp", 32'(m_bresp[1]), 32'd2);
      check_bit("skew_s_bready", s_bready, 1'b1);
      tick();
      s_bvalid = 1'b0;
      settle();
      check_word("skew_done_state", 32'(dut.state), 32'(IDLE));

      // Read-before-write: master 0 raises arvalid and awvalid together.
      m_arvalid[0] = 1'b1; m_araddr[0] = 32'h0000_0300;
      m_awvalid[0] = 1'b1; m_awaddr[0] = 32'h0000_0400;
      m_wvalid[0] = 1'b1;  m_wdata[0] = 32'h0000_0055; m_wmask[0] = 4'hF;
      s_awready = 1'b1; s_wready = 1'b1;
      awv_start = aw_valid_cycles;
      tick();
      settle();
      check_word("rbw_state_rd_addr", 32'(dut.state), 32'(RD_ADDR));
      check_bit("rbw_s_arvalid", s_arvalid, 1'b1);
      check_bit("rbw_s_awvalid_rd", s_awvalid, 1'b0);
      tick();
      m_arvalid[0] = 1'b0;
      s_rvalid = 1'b1;
      settle();
      check_bit("rbw_m0_rvalid", m_rvalid[0], 1'b1);
      check_bit("rbw_s_awvalid_rdata", s_awvalid, 1'b0);
      tick();
      s_rvalid = 1'b0;
      settle();
      check_word("rbw_no_aw_during_read", 32'(aw_valid_cycles - awv_start), 32'd0);
      tick();
      settle();
      check_bit("rbw_s_awvalid", s_awvalid, 1'b1);
      check_bit("rbw_s_wvalid", s_wvalid, 1'b1);
      tick();
      m_awvalid[0] = 1'b0; m_wvalid[0] = 1'b0;
      s_bvalid = 1'b1; s_bresp = 2'b00;
      settle();
      check_word("rbw_same_cycle_wresp", 32'(dut.state), 32'(WR_RESP));
      check_bit("rbw_m0_bvalid", m_bvalid[0], 1'b1);
      check_bit("rbw_m1_bvalid", m_bvalid[1], 1'b0);
      tick();
      s_bvalid = 1'b0;

      // Reset in WR_ADDR after the AW handshake but before W completes.
      m_awvalid[1] = 1'b1; m_awaddr[1] = 32'h0000_0500;
      m_wvalid[1] = 1'b1;  m_wdata[1] = 32'h0000_0066;
      s_awready = 1'b1; s_wready = 1'b0;
      tick();
      settle();
      check_bit("rstw_s_awvalid", s_awvalid, 1'b1);
      check_bit("rstw_m1_wready", m_wready[1], 1'b0);
      tick();
      m_awvalid[1] = 1'b0;
      settle();
      check_bit("rstw_aw_done", dut.aw_done, 1'b1);
      check_word("rstw_state", 32'(dut.state), 32'(WR_ADDR));
      check_bit("rstw_s_wvalid_pending", s_wvalid, 1'b1);
      reset = 1'b1;
      s_wready = 1'b1;
      settle();
      check_bit("rstw_in_reset_s_wvalid", s_wvalid, 1'b0);
      check_bit("rstw_in_reset_m1_wready", m_wready[1], 1'b0);
      tick();
      reset = 1'b0;
      m_wvalid[1] = 1'b0;
      s_wready = 1'b0;
      m_arvalid = 2'b11;
      m_araddr[0] = 32'h0000_0600;
      m_araddr[1] = 32'h0000_0700;
      settle();
      check_word("rstw_idle_state", 32'(dut.state), 32'(IDLE));
      check_bit("rstw_flags_cleared", dut.aw_done | dut.w_done, 1'b0);
      check_bit("rstw_idle_valids", s_arvalid | s_awvalid | s_wvalid, 1'b0);
      tick();
      settle();
      check_word("rstw_m0_wins_addr", s_araddr, 32'h0000_0600);
      check_bit("rstw_m0_arready", m_arready[0], 1'b1);
      check_bit("rstw_m1_arready", m_arready[1], 1'b0);
      tick();
      m_arvalid[0] = 1'b0;
      s_rvalid = 1'b1;
      tick();
      s_rvalid = 1'b0;
      m_arvalid[1] = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
